// File: rtl/bcd_counter_display_if.sv
// rtl/bcd_counter_display_if.sv - board-side signal bundle for the BCD counter/display block
interface bcd_counter_display_if #(
    parameter int DIGITS = 4
);
    logic                  EN;
    logic                  UP;
    logic                  LOAD;
    logic [4*DIGITS-1:0]   LOAD_VAL;
    logic [4*DIGITS-1:0]   VALUE;
    logic [7*DIGITS-1:0]   HEX;
    logic                  WRAP;

    modport master (
        output EN, UP, LOAD, LOAD_VAL,
        input  VALUE, HEX, WRAP
    );

    modport slave (
        input  EN, UP, LOAD, LOAD_VAL,
        output VALUE, HEX, WRAP
    );
endinterface

// File: rtl/bcd_counter_display.sv
// rtl/bcd_counter_display.sv - N-digit BCD up/down counter with prescaler, synchronised load and 7-seg decode
// Optional build macro BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit0.
module bcd_counter_display #(
    parameter int DIGITS  = 4,
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 10
) (
    input  logic                  CLOCK_50,
    input  logic                  RST_N,
    bcd_counter_display_if.slave  bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int VW  = 4 * DIGITS;
    localparam int HW  = 7 * DIGITS;
    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Display image of an all-zero count, used as the reset value of the HEX register.
    function automatic logic [HW-1:0] hex_reset();
        logic [HW-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
            r[7*i +: 7] = (i == 0) ? seg7(4'd0) : SEG_BLANK;
`else
            r[7*i +: 7] = seg7(4'd0);
`endif
        end
        return r;
    endfunction

    localparam logic [HW-1:0] HEX_RST = hex_reset();

    logic          sync1_q, sync2_q, prev_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [VW-1:0] value_q, value_d;
    logic          wrap_q, wrap_d;
    logic [HW-1:0] hex_q, hex_d;
    logic          load_edge;
    logic          tick;
    logic          carry;

    assign load_edge = sync2_q & ~prev_q;
    assign tick      = bus.EN & (presc_q == DIV_LAST);

    always_comb begin
        presc_d = presc_q;
        value_d = value_q;
        wrap_d  = 1'b0;
        carry   = 1'b1;
        if (load_edge) begin
            presc_d = '0;
            for (int i = 0; i < DIGITS; i++) begin
                value_d[4*i +: 4] = (bus.LOAD_VAL[4*i +: 4] > 4'd9) ? 4'd9 : bus.LOAD_VAL[4*i +: 4];
            end
        end else if (bus.EN) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                // Ripple carry/borrow; surviving past the top digit means every digit rolled over.
                for (int i = 0; i < DIGITS; i++) begin
                    if (carry) begin
                        if (bus.UP) begin
                            if (value_q[4*i +: 4] == 4'd9) begin
                                value_d[4*i +: 4] = 4'd0;
                            end else begin
                                value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                                carry = 1'b0;
                            end
                        end else begin
                            if (value_q[4*i +: 4] == 4'd0) begin
                                value_d[4*i +: 4] = 4'd9;
                            end else begin
                                value_d[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
                                carry = 1'b0;
                            end
                        end
                    end
                end
                wrap_d = carry;
            end
        end
    end

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic leading;
`endif

    always_comb begin
        hex_d = '0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        leading = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (leading && (i != 0) && (value_q[4*i +: 4] == 4'd0)) begin
                hex_d[7*i +: 7] = SEG_BLANK;
            end else begin
                leading = 1'b0;
                hex_d[7*i +: 7] = seg7(value_q[4*i +: 4]);
            end
        end
`else
        for (int i = 0; i < DIGITS; i++) begin
            hex_d[7*i +: 7] = seg7(value_q[4*i +: 4]);
        end
`endif
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            presc_q <= '0;
            value_q <= '0;
            wrap_q  <= 1'b0;
            hex_q   <= HEX_RST;
        end else begin
            sync1_q <= bus.LOAD;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            presc_q <= presc_d;
            value_q <= value_d;
            wrap_q  <= wrap_d;
            hex_q   <= hex_d;
        end
    end

    assign bus.VALUE = value_q;
    assign bus.WRAP  = wrap_q;
    assign bus.HEX   = hex_q;
endmodule

// File: tb/tb_bcd_counter_display.sv
// tb/tb_bcd_counter_display.sv - directed bench with decimal reference model for bcd_counter_display
module tb_bcd_counter_display;
    localparam int DIV = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   wrap_seen = 0;
    int   w0;
    bit   chk_on = 1'b0;

    logic [6:0] seg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    bcd_counter_display_if #(.DIGITS(4)) bus ();

    bcd_counter_display #(.DIGITS(4), .CLK_HZ(10), .TICK_HZ(1)) dut (
        .CLOCK_50 (clk),
        .RST_N    (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int m_val, m_presc, m_hexv;
    bit m_s1, m_s2, m_prev, m_wrap, m_edge, m_tick;

    function automatic int clamp_dec(logic [15:0] v);
        int r;
        int d;
        r = 0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            r = r * 10 + d;
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(int n);
        logic [15:0] r;
        int rest;
        rest = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(rest % 10);
            rest = rest / 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] exp_hex(int n);
        logic [27:0] r;
        int rest;
        rest = n;
        for (int i = 0; i < 4; i++) begin
            r[7*i +: 7] = seg[rest % 10];
`ifdef BCD_LEADING_ZERO_BLANK_EN
            if (i > 0 && n < 10 ** i) r[7*i +: 7] = 7'b1111111;
`endif
            rest = rest / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count kept as a plain decimal integer, load pipeline as three sampled bits.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_val = 0; m_presc = 0; m_hexv = 0;
            m_s1 = 0; m_s2 = 0; m_prev = 0; m_wrap = 0;
        end else begin
            m_edge = m_s2 && !m_prev;
            m_tick = bus.EN && (m_presc == DIV - 1);
            m_hexv = m_val;
            m_prev = m_s2;
            m_s2   = m_s1;
            m_s1   = bus.LOAD;
            m_wrap = 0;
            if (m_edge) begin
                m_val   = clamp_dec(bus.LOAD_VAL);
                m_presc = 0;
            end else if (bus.EN) begin
                m_presc = (m_presc + 1) % DIV;
                if (m_tick) begin
                    if (bus.UP) begin
                        if (m_val == 9999) begin m_val = 0; m_wrap = 1; end
                        else m_val = m_val + 1;
                    end else begin
                        if (m_val == 0) begin m_val = 9999; m_wrap = 1; end
                        else m_val = m_val - 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("VALUE", 32'(bus.VALUE), 32'(to_bcd(m_val)));
            chk("WRAP",  32'(bus.WRAP),  32'(m_wrap));
            chk("HEX",   32'(bus.HEX),   32'(exp_hex(m_hexv)));
            if (bus.WRAP === 1'b1) wrap_seen++;
        end
    end

    logic [27:0] hex_rst_lit;
    logic [27:0] hex_0007_lit;

    initial begin
`ifdef BCD_LEADING_ZERO_BLANK_EN
        hex_rst_lit  = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
        hex_0007_lit = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000};
`else
        hex_rst_lit  = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
        hex_0007_lit = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000};
`endif
        bus.EN = 1'b0; bus.UP = 1'b1; bus.LOAD = 1'b0; bus.LOAD_VAL = 16'h0000;
        @(posedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset VALUE", 32'(bus.VALUE), 32'h0);
        chk("reset HEX", 32'(bus.HEX), 32'(hex_rst_lit));
        rst_n = 1'b1;

        // Count up 25 ticks
        bus.EN = 1'b1;
        repeat (250) @(negedge clk);
        bus.EN = 1'b0;
        chk("count25 VALUE", 32'(bus.VALUE), 32'h0025);
        @(negedge clk);
        chk("count25 HEX0", 32'(bus.HEX[6:0]), 32'(7'b0010010));
        chk("count25 HEX1", 32'(bus.HEX[13:7]), 32'(7'b0100100));

        // Hold: prescaler keeps its phase across an EN=0 stretch
        bus.EN = 1'b1; repeat (3) @(negedge clk);
        bus.EN = 1'b0; repeat (100) @(negedge clk);
        chk("hold VALUE", 32'(bus.VALUE), 32'h0025);
        bus.EN = 1'b1; repeat (7) @(negedge clk);
        chk("hold resume VALUE", 32'(bus.VALUE), 32'h0026);

        // Load with a coincident tick on the load edge
        repeat (7) @(negedge clk);
        bus.LOAD_VAL = 16'h12F7; bus.LOAD = 1'b1;
        repeat (2) @(negedge clk);
        chk("load pre VALUE", 32'(bus.VALUE), 32'h0026);
        @(negedge clk);
        chk("load VALUE", 32'(bus.VALUE), 32'h1297);
        bus.EN = 1'b0; bus.LOAD_VAL = 16'h0000;
        repeat (47) @(negedge clk);
        chk("held load VALUE", 32'(bus.VALUE), 32'h1297);
        bus.LOAD = 1'b0; bus.EN = 1'b1;
        repeat (10) @(negedge clk);
        chk("post load tick VALUE", 32'(bus.VALUE), 32'h1298);

        // Wrap up then down; 9F99 also exercises clamping
        bus.EN = 1'b0; bus.LOAD_VAL = 16'h9F99; bus.LOAD = 1'b1;
        @(negedge clk); bus.LOAD = 1'b0;
        repeat (4) @(negedge clk);
        chk("clamp VALUE", 32'(bus.VALUE), 32'h9999);
        w0 = wrap_seen; bus.UP = 1'b1; bus.EN = 1'b1;
        repeat (10) @(negedge clk);
        bus.EN = 1'b0; @(negedge clk);
        chk("wrap up VALUE", 32'(bus.VALUE), 32'h0000);
        chk("wrap up pulses", 32'(wrap_seen - w0), 32'd1);
        w0 = wrap_seen; bus.UP = 1'b0; bus.EN = 1'b1;
        repeat (10) @(negedge clk);
        bus.EN = 1'b0; @(negedge clk);
        chk("wrap down VALUE", 32'(bus.VALUE), 32'h9999);
        chk("wrap down pulses", 32'(wrap_seen - w0), 32'd1);

        // Leading-zero display
        bus.LOAD_VAL = 16'h0007; bus.LOAD = 1'b1;
        @(negedge clk); bus.LOAD = 1'b0;
        repeat (5) @(negedge clk);
        chk("0007 HEX", 32'(bus.HEX), 32'(hex_0007_lit));

        // Async reset mid-count with a load edge in flight
        bus.UP = 1'b1; bus.EN = 1'b1; bus.LOAD_VAL = 16'h4321;
        repeat (13) @(negedge clk);
        bus.LOAD = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0; bus.LOAD = 1'b0;
        #1;
        chk("async VALUE", 32'(bus.VALUE), 32'h0);
        chk("async WRAP", 32'(bus.WRAP), 32'h0);
        chk("async HEX", 32'(bus.HEX), 32'(hex_rst_lit));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("discarded load VALUE", 32'(bus.VALUE), 32'h0);
        repeat (4) @(negedge clk);
        chk("post reset tick VALUE", 32'(bus.VALUE), 32'h0001);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
